// File: rtl/spi_pkg.sv
// Shared command, select-polarity and FSM state definitions for the SPI RAM slave.
package spi_pkg;

   typedef enum logic [1:0] {
      WR_ADDR = 2'b00,
      WR_DATA = 2'b01,
      RD_ADDR = 2'b10,
      RD_DATA = 2'b11
   } spi_cmd_e;

   localparam logic SLAVE_SELECTED = 1'b0;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      PAYLOAD,
      WR_BURST,
      RD_FETCH,
      RD_SHIFT
   } spi_ram_state_e;

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port synchronous RAM, one-cycle registered read.
module spi_ram_mem #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned MEM_DEPTH  = 256
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   // Write when enabled; read port always registers the addressed word.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/spi_ram_slave_burst.sv
// SPI RAM slave with parametrised widths, auto-increment bursts and a sticky
// out-of-range address flag.
module spi_ram_slave_burst
   import spi_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned MEM_DEPTH  = 256,
   parameter int unsigned AUTO_INC   = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic SS_n,
   input  logic MOSI,
   output logic MISO,
   output logic miso_valid,
   output logic busy,
   output logic addr_err
);

   localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
   localparam int unsigned AX_W  = ADDR_WIDTH + 1;
   localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(DATA_WIDTH - 1);
   localparam logic [AX_W-1:0]       DEPTH_X   = AX_W'(MEM_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(MEM_DEPTH - 1);

   spi_ram_state_e        state;
   spi_cmd_e              cmd;
   logic                  cmd_hi;
   logic [CNT_W-1:0]      cnt;
   logic [DATA_WIDTH-1:0] shreg;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  rd_oor;
   logic [DATA_WIDTH-1:0] rdata;

   logic                  sel_c;
   logic                  last_c;
   logic                  addr_ok_c;
   logic                  pay_ok_c;
   logic                  we_c;
   logic [DATA_WIDTH-1:0] payload_c;
   logic [DATA_WIDTH-1:0] tx_word_c;
   logic [ADDR_WIDTH-1:0] pay_addr_c;
   logic [ADDR_WIDTH-1:0] addr_inc_c;

   // Datapath decode: incoming word, range checks, wrapped increment, write strobe.
   always_comb begin
      sel_c      = (SS_n == SLAVE_SELECTED);
      last_c     = (cnt == CNT_LAST);
      payload_c  = {shreg[DATA_WIDTH-2:0], MOSI};
      pay_addr_c = payload_c[ADDR_WIDTH-1:0];
      addr_ok_c  = ({1'b0, addr} < DEPTH_X);
      pay_ok_c   = ({1'b0, pay_addr_c} < DEPTH_X);
      addr_inc_c = (addr == ADDR_LAST) ? '0 : addr + ADDR_WIDTH'(1);
      tx_word_c  = (cnt == '0) ? (rd_oor ? '0 : rdata) : shreg;
      we_c       = !rst && sel_c && last_c && addr_ok_c &&
                   ((state == PAYLOAD && cmd == WR_DATA) || state == WR_BURST);
   end

   spi_ram_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .MEM_DEPTH  (MEM_DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (we_c),
      .addr  (addr),
      .wdata (payload_c),
      .rdata (rdata)
   );

   // Frame FSM: command/payload collection, execution, read serialisation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cmd        <= WR_ADDR;
         cmd_hi     <= 1'b0;
         cnt        <= '0;
         shreg      <= '0;
         addr       <= '0;
         rd_oor     <= 1'b0;
         MISO       <= 1'b0;
         miso_valid <= 1'b0;
         busy       <= 1'b0;
         addr_err   <= 1'b0;
      end else if (!sel_c) begin
         state      <= IDLE;
         cnt        <= '0;
         shreg      <= '0;
         MISO       <= 1'b0;
         miso_valid <= 1'b0;
         busy       <= 1'b0;
      end else begin
         busy       <= 1'b1;
         MISO       <= 1'b0;
         miso_valid <= 1'b0;
         case (state)
            IDLE: begin
               // cnt = 1 tells CMD the first command bit is already held.
               cmd_hi <= MOSI;
               cnt    <= CNT_W'(1);
               state  <= CMD;
            end
            CMD: begin
               if (cnt == '0) begin
                  cmd_hi <= MOSI;
                  cnt    <= CNT_W'(1);
               end else begin
                  cmd   <= spi_cmd_e'({cmd_hi, MOSI});
                  cnt   <= '0;
                  state <= PAYLOAD;
               end
            end
            PAYLOAD: begin
               shreg <= payload_c;
               if (last_c) begin
                  cnt <= '0;
                  case (cmd)
                     WR_ADDR, RD_ADDR: begin
                        if (pay_ok_c) begin
                           addr <= pay_addr_c;
                        end else begin
                           addr_err <= 1'b1;
                        end
                        state <= CMD;
                     end
                     WR_DATA: begin
                        if (AUTO_INC != 0) begin
                           addr  <= addr_inc_c;
                           state <= WR_BURST;
                        end else begin
                           state <= CMD;
                        end
                     end
                     RD_DATA: state <= RD_FETCH;
                     default: state <= CMD;
                  endcase
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            WR_BURST: begin
               shreg <= payload_c;
               if (last_c) begin
                  cnt  <= '0;
                  addr <= addr_inc_c;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RD_FETCH: begin
               // RAM registers mem[addr] at this edge; remember if it was out of range.
               rd_oor <= !addr_ok_c;
               if (AUTO_INC != 0) begin
                  addr <= addr_inc_c;
               end
               cnt   <= '0;
               state <= RD_SHIFT;
            end
            RD_SHIFT: begin
               MISO       <= tx_word_c[DATA_WIDTH-1];
               miso_valid <= 1'b1;
               shreg      <= {tx_word_c[DATA_WIDTH-2:0], 1'b0};
               if (last_c) begin
                  cnt   <= '0;
                  state <= (AUTO_INC != 0) ? RD_FETCH : CMD;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_ram_slave_burst.sv
// Bench for spi_ram_slave_burst: a legacy instance (AUTO_INC=0, depth 200) and
// a burst instance (AUTO_INC=1, depth 256) share clock and reset.
module tb_spi_ram_slave_burst;
   import spi_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic ss_n [2];
   logic mosi [2];
   logic miso [2];
   logic mv   [2];
   logic busy [2];
   logic aerr [2];

   int checks = 0;
   int errors = 0;
   bit q0 [$];
   bit q1 [$];

   always #5 clk = ~clk;

   spi_ram_slave_burst #(
      .DATA_WIDTH (8), .ADDR_WIDTH (8), .MEM_DEPTH (200), .AUTO_INC (0)
   ) u0 (
      .clk (clk), .rst (rst), .SS_n (ss_n[0]), .MOSI (mosi[0]),
      .MISO (miso[0]), .miso_valid (mv[0]), .busy (busy[0]), .addr_err (aerr[0])
   );

   spi_ram_slave_burst #(
      .DATA_WIDTH (8), .ADDR_WIDTH (8), .MEM_DEPTH (256), .AUTO_INC (1)
   ) u1 (
      .clk (clk), .rst (rst), .SS_n (ss_n[1]), .MOSI (mosi[1]),
      .MISO (miso[1]), .miso_valid (mv[1]), .busy (busy[1]), .addr_err (aerr[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard: every valid MISO bit is matched against the oldest expected bit.
   always @(negedge clk) begin
      if (mv[0] === 1'b1) begin
         if (q0.size() == 0) check("u0_unexpected_valid", 32'(mv[0]), 32'd0);
         else check("u0_miso", 32'(miso[0]), 32'(q0.pop_front()));
      end
      if (mv[1] === 1'b1) begin
         if (q1.size() == 0) check("u1_unexpected_valid", 32'(mv[1]), 32'd0);
         else check("u1_miso", 32'(miso[1]), 32'(q1.pop_front()));
      end
   end

   function automatic int qsize(input int i);
      return (i == 0) ? q0.size() : q1.size();
   endfunction

   task automatic push_bits(input int i, input logic [7:0] w, input int n);
      for (int b = 7; b >= 8 - n; b--) begin
         if (i == 0) q0.push_back(w[b]);
         else        q1.push_back(w[b]);
      end
   endtask

   task automatic drive_bits(input int i, input logic [31:0] v, input int n);
      for (int b = n - 1; b >= 0; b--) begin
         @(negedge clk);
         ss_n[i] = 1'b0;
         mosi[i] = v[b];
      end
   endtask

   task automatic frame(input int i, input spi_cmd_e c, input logic [7:0] p);
      drive_bits(i, 32'(c), 2);
      drive_bits(i, 32'(p), 8);
   endtask

   task automatic release_ss(input int i);
      @(negedge clk);
      ss_n[i] = 1'b1;
      mosi[i] = 1'b0;
   endtask

   // RD_DATA frame then nwords read words; checks miso_valid timing every cycle.
   task automatic read_run(input int i, input int nwords, input logic [23:0] words);
      int m;
      logic expv;
      for (int j = 0; j < nwords; j++) push_bits(i, words[23 - 8*j -: 8], 8);
      frame(i, RD_DATA, 8'h00);
      for (int k = 1; k <= 9*nwords + 1; k++) begin
         @(negedge clk);
         m = k - 1;
         expv = (m >= 2) && ((m - 1) % 9 != 0);
         check($sformatf("u%0d_valid_edge_N+%0d", i, m), 32'(mv[i]), 32'(expv));
         if (k == 1) check($sformatf("u%0d_busy_fetch", i), 32'(busy[i]), 32'd1);
         ss_n[i] = (k == 9*nwords + 1);
         mosi[i] = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      check($sformatf("u%0d_bits_outstanding", i), 32'(qsize(i)), 32'd0);
      check($sformatf("u%0d_miso_after", i), 32'(miso[i]), 32'd0);
      check($sformatf("u%0d_busy_after", i), 32'(busy[i]), 32'd0);
   endtask

   // RD_DATA frame kept selected until three bits have shifted out.
   task automatic rd_partial(input int i, input logic [7:0] w);
      push_bits(i, w, 3);
      frame(i, RD_DATA, 8'h00);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         ss_n[i] = 1'b0;
         mosi[i] = 1'b0;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         ss_n[i] = 1'b1;
         mosi[i] = 1'b0;
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("u%0d_rst_miso", i), 32'(miso[i]), 32'd0);
         check($sformatf("u%0d_rst_valid", i), 32'(mv[i]), 32'd0);
         check($sformatf("u%0d_rst_busy", i), 32'(busy[i]), 32'd0);
         check($sformatf("u%0d_rst_addr_err", i), 32'(aerr[i]), 32'd0);
      end

      // MOSI activity while deselected must not wake the slave.
      for (int k = 0; k < 6; k++) begin
         mosi[0] = ~mosi[0];
         @(negedge clk);
         check("u0_idle_busy", 32'(busy[0]), 32'd0);
         check("u0_idle_miso", 32'(miso[0]), 32'd0);
      end

      // Legacy single access, back-to-back frames.
      frame(0, WR_ADDR, 8'h3C);
      @(negedge clk);
      check("u0_busy_in_frame", 32'(busy[0]), 32'd1);
      ss_n[0] = 1'b0;
      drive_bits(0, 32'(WR_DATA), 1);
      drive_bits(0, 32'(8'hA5), 8);
      frame(0, RD_ADDR, 8'h3C);
      read_run(0, 1, 24'hA5_0000);
      read_run(0, 1, 24'hA5_0000);

      // Burst write across the wrap point, then burst read back.
      frame(1, WR_ADDR, 8'hFE);
      frame(1, WR_DATA, 8'h11);
      drive_bits(1, 32'(8'h22), 8);
      drive_bits(1, 32'(8'h33), 8);
      release_ss(1);
      @(negedge clk);
      check("u1_burst_wr_busy", 32'(busy[1]), 32'd0);
      frame(1, RD_ADDR, 8'hFE);
      read_run(1, 3, 24'h112233);
      frame(1, RD_ADDR, 8'h00);
      read_run(1, 1, 24'h33_0000);

      // Out-of-range address on the depth-200 slave.
      frame(0, WR_ADDR, 8'h10);
      @(negedge clk);
      check("u0_aerr_before", 32'(aerr[0]), 32'd0);
      ss_n[0] = 1'b0;
      drive_bits(0, 32'(WR_ADDR), 1);
      drive_bits(0, 32'(8'hC8), 8);
      @(negedge clk);
      check("u0_aerr_set", 32'(aerr[0]), 32'd1);
      ss_n[0] = 1'b0;
      drive_bits(0, 32'(WR_DATA), 1);
      drive_bits(0, 32'(8'h5A), 8);
      read_run(0, 1, 24'h5A_0000);
      repeat (5) @(negedge clk);
      check("u0_aerr_sticky", 32'(aerr[0]), 32'd1);

      // Aborted write leaves memory untouched.
      frame(0, WR_ADDR, 8'h20);
      frame(0, WR_DATA, 8'h99);
      release_ss(0);
      drive_bits(0, 32'(WR_DATA), 2);
      drive_bits(0, 32'h0E, 5);
      release_ss(0);
      @(negedge clk);
      check("u0_abort_busy", 32'(busy[0]), 32'd0);
      read_run(0, 1, 24'h99_0000);

      // Deselect in the middle of a read word.
      rd_partial(0, 8'h99);
      release_ss(0);
      @(negedge clk);
      check("u0_abort_rd_miso", 32'(miso[0]), 32'd0);
      check("u0_abort_rd_valid", 32'(mv[0]), 32'd0);
      check("u0_abort_rd_bits", 32'(qsize(0)), 32'd0);

      // Reset in the middle of a read word.
      rd_partial(0, 8'h99);
      @(negedge clk);
      rst     = 1'b1;
      ss_n[0] = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("u0_rst_rd_miso", 32'(miso[0]), 32'd0);
      check("u0_rst_rd_valid", 32'(mv[0]), 32'd0);
      check("u0_rst_rd_busy", 32'(busy[0]), 32'd0);
      check("u0_rst_rd_addr_err", 32'(aerr[0]), 32'd0);
      check("u0_rst_rd_bits", 32'(qsize(0)), 32'd0);
      frame(0, WR_ADDR, 8'h20);
      read_run(0, 1, 24'h99_0000);
      frame(0, WR_ADDR, 8'h3C);
      read_run(0, 1, 24'hA5_0000);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
